// File: rtl/xv_pkg.sv
// Shared types for the byte-to-word register bridge: dtack encoding,
// byte/word types and the bridge state enum.
package xv;
  localparam logic DTACK_ACK = 1'b1;
  localparam logic DTACK_NAK = 1'b0;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;
endpackage

// File: rtl/reg_rd_timer.sv
// Read-wait watchdog for reg_byte_bridge; only built when REG_RD_TIMEOUT_EN
// is defined. expired fires in the CYCLES-th consecutive run cycle without ack.
`ifdef REG_RD_TIMEOUT_EN
module reg_rd_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic expired
);
  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start || !run || ack)
      cnt_d = '0;
    else if (cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  // An ack in the same cycle wins over expiry.
  assign expired = run && !ack && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
endmodule
`endif

// File: rtl/reg_byte_bridge.sv
// Byte-wide bus to 16-bit register bridge with even-byte write latch and
// odd-byte read cache. Optional read watchdog under REG_RD_TIMEOUT_EN.
module reg_byte_bridge
  import xv::*;
#(
  parameter int unsigned RD_TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        write_strobe_i,
  input  logic        read_strobe_i,
  input  logic [3:0]  reg_num_i,
  input  logic        bytesel_i,
  input  logic [7:0]  bytedata_i,
  output logic [7:0]  bus_data_o,
  output logic        bus_dtack_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [3:0]  reg_num_o,
  output logic [15:0] reg_data_o,
  input  logic [15:0] reg_data_i,
  input  logic        reg_rd_ack_i,
  output logic        timeout_o
);
  state_t     state_q, state_d;
  byte_t      bus_data_q, bus_data_d;
  byte_t      msb_q, msb_d;
  byte_t      lsb_q, lsb_d;
  logic       lsb_valid_q, lsb_valid_d;
  logic [3:0] lsb_reg_q, lsb_reg_d;
  logic [3:0] reg_num_q, reg_num_d;
  word_t      reg_data_q, reg_data_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       rd_odd_q, rd_odd_d;

  logic accept, do_wr, do_rd, rd_hit, ack_ok;

  assign accept = (state_q != RD_WAIT);
  assign do_wr  = accept && write_strobe_i;
  assign do_rd  = accept && read_strobe_i && !write_strobe_i;
  assign rd_hit = bytesel_i && lsb_valid_q && (reg_num_i == lsb_reg_q);
  assign ack_ok = (state_q == RD_WAIT) && reg_rd_ack_i;

`ifdef REG_RD_TIMEOUT_EN
  logic tmo_exp;
  logic timeout_q, timeout_d;

  reg_rd_timer #(.CYCLES(RD_TIMEOUT_CYCLES)) u_rd_timer (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .start     (do_rd && !rd_hit),
    .run       (state_q == RD_WAIT),
    .ack       (reg_rd_ack_i),
    .expired   (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n_i) timeout_q <= 1'b0;
    else            timeout_q <= timeout_d;
  end

  assign timeout_o = timeout_q;
`else
  // Parameter only matters with the watchdog built in.
  logic unused_cfg;
  assign unused_cfg = ^RD_TIMEOUT_CYCLES;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_data_d  = bus_data_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    lsb_valid_d = lsb_valid_q;
    lsb_reg_d   = lsb_reg_q;
    reg_num_d   = reg_num_q;
    reg_data_d  = reg_data_q;
    rd_odd_d    = rd_odd_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
`ifdef REG_RD_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    if (do_wr) begin
      lsb_valid_d = 1'b0;
      state_d     = ACK;
      if (bytesel_i) begin
        reg_wr_d   = 1'b1;
        reg_num_d  = reg_num_i;
        reg_data_d = {msb_q, bytedata_i};
      end else begin
        msb_d = bytedata_i;
      end
    end else if (do_rd) begin
      if (rd_hit) begin
        bus_data_d  = lsb_q;
        lsb_valid_d = 1'b0;
        state_d     = ACK;
      end else begin
        reg_rd_d  = 1'b1;
        reg_num_d = reg_num_i;
        rd_odd_d  = bytesel_i;
        state_d   = RD_WAIT;
        // An odd miss leaves the cache empty.
        if (bytesel_i) lsb_valid_d = 1'b0;
      end
    end else if (ack_ok) begin
      state_d = ACK;
      if (rd_odd_q) begin
        bus_data_d = reg_data_i[7:0];
      end else begin
        bus_data_d  = reg_data_i[15:8];
        lsb_d       = reg_data_i[7:0];
        lsb_valid_d = 1'b1;
        lsb_reg_d   = reg_num_q;
      end
`ifdef REG_RD_TIMEOUT_EN
    end else if (tmo_exp) begin
      state_d     = ACK;
      bus_data_d  = 8'hFF;
      lsb_valid_d = 1'b0;
      timeout_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      bus_data_q  <= 8'h00;
      msb_q       <= 8'h00;
      lsb_q       <= 8'h00;
      lsb_valid_q <= 1'b0;
      lsb_reg_q   <= 4'h0;
      reg_num_q   <= 4'h0;
      reg_data_q  <= 16'h0000;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_odd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_data_q  <= bus_data_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_reg_q   <= lsb_reg_d;
      reg_num_q   <= reg_num_d;
      reg_data_q  <= reg_data_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rd_odd_q    <= rd_odd_d;
    end
  end

  // Dtack drops combinationally in the cycle a new access is accepted.
  assign bus_dtack_o = ((state_q == ACK) && !do_wr && !do_rd) ? DTACK_ACK : DTACK_NAK;
  assign bus_data_o  = bus_data_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign reg_num_o   = reg_num_q;
  assign reg_data_o  = reg_data_q;
endmodule

// File: tb/tb_reg_byte_bridge.sv
// Self-checking bench for reg_byte_bridge: the backend is a 16-word register
// file, so every completed read must return a byte of that memory.
module tb_reg_byte_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        write_strobe_i = 1'b0, read_strobe_i = 1'b0;
  logic [3:0]  reg_num_i = '0;
  logic        bytesel_i = 1'b0;
  logic [7:0]  bytedata_i = '0;
  logic [7:0]  bus_data_o;
  logic        bus_dtack_o, reg_wr_o, reg_rd_o, timeout_o;
  logic [3:0]  reg_num_o;
  logic [15:0] reg_data_o;
  logic [15:0] reg_data_i = '0;
  logic        reg_rd_ack_i = 1'b0;

  always #5 clk = ~clk;

  reg_byte_bridge #(.RD_TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .write_strobe_i(write_strobe_i), .read_strobe_i(read_strobe_i),
    .reg_num_i(reg_num_i), .bytesel_i(bytesel_i), .bytedata_i(bytedata_i),
    .bus_data_o(bus_data_o), .bus_dtack_o(bus_dtack_o),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
    .reg_num_o(reg_num_o), .reg_data_o(reg_data_o),
    .reg_data_i(reg_data_i), .reg_rd_ack_i(reg_rd_ack_i),
    .timeout_o(timeout_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: backend memory, even-byte shadow, odd-byte cache tag.
  logic [15:0] mem [16];
  logic [7:0]  msb_m;
  bit          cache_v;
  logic [3:0]  cache_r;
  bit          m_ack;

  // Per-cycle expectations
  bit          chk_en = 0;
  logic        e_dtack, e_wr, e_rd, e_tmo, e_rst;
  logic [3:0]  e_num;
  logic [15:0] e_wdata;
  logic [7:0]  e_bus;

  int          n_wr = 0, n_rd = 0;
  logic [3:0]  last_num;
  logic [15:0] last_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dtack",    32'(bus_dtack_o), 32'(e_dtack));
      chk("reg_wr",   32'(reg_wr_o),    32'(e_wr));
      chk("reg_rd",   32'(reg_rd_o),    32'(e_rd));
      chk("bus_data", 32'(bus_data_o),  32'(e_bus));
      chk("timeout",  32'(timeout_o),   32'(e_tmo));
      if (e_wr || e_rd || e_rst) chk("reg_num",  32'(reg_num_o),  32'(e_num));
      if (e_wr || e_rst)         chk("reg_data", 32'(reg_data_o), 32'(e_wdata));
      if (reg_wr_o) begin n_wr++; last_num = reg_num_o; last_wdata = reg_data_o; end
      if (reg_rd_o) n_rd++;
    end
  end

  // Advance one cycle; idle inputs carry junk that must be ignored.
  task automatic cyc();
    @(posedge clk); #1;
    write_strobe_i = 1'b0; read_strobe_i = 1'b0; reg_rd_ack_i = 1'b0;
    reg_num_i  = 4'($urandom); bytesel_i = 1'($urandom);
    bytedata_i = 8'($urandom); reg_data_i = 16'($urandom);
    e_wr = 1'b0; e_rd = 1'b0; e_rst = 1'b0;
  endtask

  task automatic reset_pulse();
    cyc(); reset_n_i = 1'b0; chk_en = 0;
    cyc(); reset_n_i = 1'b1; chk_en = 1;
    e_dtack = xv::DTACK_NAK; e_bus = 8'h00; e_tmo = 1'b0;
    e_rst = 1'b1; e_num = 4'h0; e_wdata = 16'h0000;
    msb_m = 8'h00; cache_v = 0; m_ack = 0;
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      cyc();
      e_dtack = m_ack ? xv::DTACK_ACK : xv::DTACK_NAK;
      if (spurious && $urandom_range(0, 1) == 1) reg_rd_ack_i = 1'b1;
    end
  endtask

  task automatic do_write(input logic [3:0] r, input logic sel, input logic [7:0] b, input bit both);
    cyc();
    write_strobe_i = 1'b1; read_strobe_i = both;
    reg_num_i = r; bytesel_i = sel; bytedata_i = b;
    e_dtack = xv::DTACK_NAK;
    cyc();
    e_dtack = xv::DTACK_ACK;
    if (sel) begin
      e_wr = 1'b1; e_num = r; e_wdata = {msb_m, b};
      mem[r] = {msb_m, b};
    end else begin
      msb_m = b;
    end
    cache_v = 0; m_ack = 1;
  endtask

  // lat: cycle (1 = the reg_rd_o cycle) in which the backend acks; 0 = never.
  task automatic do_read(input logic [3:0] r, input logic sel, input int lat, input bit noise);
    cyc();
    read_strobe_i = 1'b1; reg_num_i = r; bytesel_i = sel;
    e_dtack = xv::DTACK_NAK;
    if (sel && cache_v && cache_r == r) begin
      cyc();
      e_dtack = xv::DTACK_ACK; e_bus = mem[r][7:0]; cache_v = 0;
    end else begin
      for (int k = 1; k <= TMO + 4; k++) begin
        cyc();
        e_dtack = xv::DTACK_NAK;
        if (k == 1) begin
          e_rd = 1'b1; e_num = r;
          if (noise) begin write_strobe_i = 1'b1; read_strobe_i = 1'($urandom); end
        end
        if (lat != 0 && k == lat) begin
          reg_rd_ack_i = 1'b1; reg_data_i = mem[r];
          break;
        end
        if (lat == 0 && k == TMO) break;
      end
      cyc();
      e_dtack = xv::DTACK_ACK;
      if (lat != 0) begin
        e_bus = sel ? mem[r][7:0] : mem[r][15:8];
        cache_v = !sel; cache_r = r;
      end else begin
        e_bus = 8'hFF; e_tmo = 1'b1; cache_v = 0;
      end
    end
    m_ack = 1;
  endtask

  int w0, r0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hABCD; mem[6] = 16'h00EE;
    reset_pulse();
    idle(2, 1);

    // Even/odd write pair builds one word write
    w0 = n_wr;
    do_write(4'h3, 1'b0, 8'h12, 0);
    do_write(4'h3, 1'b1, 8'h34, 0);
    idle(1, 0);
    chk("wr_pair_count", 32'(n_wr - w0), 32'd1);
    chk("wr_pair_num",   32'(last_num),   32'h3);
    chk("wr_pair_data",  32'(last_wdata), 32'h1234);

    // Even read then cached odd read
    r0 = n_rd;
    do_read(4'h5, 1'b0, 4, 0);
    chk("rd_even_byte", 32'(bus_data_o), 32'hAB);
    do_read(4'h5, 1'b1, 2, 0);
    chk("rd_odd_hit_byte", 32'(bus_data_o), 32'hCD);
    idle(1, 0);
    chk("rd_hit_no_req", 32'(n_rd - r0), 32'd1);

    // Odd read of a different register misses
    r0 = n_rd;
    do_read(4'h5, 1'b0, 1, 0);
    do_read(4'h6, 1'b1, 3, 0);
    chk("rd_odd_miss_byte", 32'(bus_data_o), 32'hEE);
    idle(1, 0);
    chk("rd_miss_reqs", 32'(n_rd - r0), 32'd2);

    // Write invalidates the cache
    r0 = n_rd;
    do_read(4'h2, 1'b0, 2, 0);
    do_write(4'h2, 1'b0, 8'h55, 0);
    do_read(4'h2, 1'b1, 2, 0);
    idle(1, 0);
    chk("wr_invalidates", 32'(n_rd - r0), 32'd2);

    // Simultaneous strobes: write wins; ignored strobes during RD_WAIT
    w0 = n_wr; r0 = n_rd;
    do_write(4'h9, 1'b1, 8'h77, 1);
    do_read(4'h9, 1'b0, 3, 1);
    idle(1, 0);
    chk("both_strobe_wr", 32'(n_wr - w0), 32'd1);
    chk("both_strobe_rd", 32'(n_rd - r0), 32'd1);
    idle(4, 1);

`ifdef REG_RD_TIMEOUT_EN
    do_read(4'h8, 1'b0, 0, 0);
    chk("tmo_byte", 32'(bus_data_o), 32'hFF);
    chk("tmo_flag", 32'(timeout_o),  32'h1);
    idle(3, 1);
    do_read(4'h8, 1'b1, 2, 0);
    chk("tmo_sticky", 32'(timeout_o), 32'h1);
    do_read(4'h8, 1'b0, TMO, 0);
    reset_pulse();
`endif

    // Randomized traffic over a few registers so cache hits occur
    for (int it = 0; it < 250; it++) begin
      logic [3:0] r;
      int op;
      int lat;
      r  = 4'($urandom_range(0, 3));
      op = $urandom_range(0, 4);
`ifdef REG_RD_TIMEOUT_EN
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
`else
      lat = $urandom_range(1, 5);
`endif
      case (op)
        0:       do_write(r, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        1:       do_read(r, 1'($urandom), lat, 1'($urandom));
        2: begin
                 do_read(r, 1'b0, lat, 0);
                 do_read(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : r,
                         1'b1, $urandom_range(1, 4), 0);
               end
        3:       idle($urandom_range(1, 3), 1);
        default: if ($urandom_range(0, 15) == 0) reset_pulse();
                 else do_write(r, 1'b0, 8'($urandom), 0);
      endcase
    end

    // Reset in RD_WAIT abandons the read; a late ack is ignored
    do_write(4'h1, 1'b0, 8'h3C, 0);
    cyc(); read_strobe_i = 1'b1; reg_num_i = 4'h7; bytesel_i = 1'b0; e_dtack = xv::DTACK_NAK;
    cyc(); e_rd = 1'b1; e_num = 4'h7; e_dtack = xv::DTACK_NAK;
    reset_pulse();
    cyc(); reg_rd_ack_i = 1'b1; reg_data_i = 16'hBEEF;
    e_dtack = xv::DTACK_NAK; e_rst = 1'b1; e_num = 4'h0; e_wdata = 16'h0;
    cyc(); e_dtack = xv::DTACK_NAK; e_rst = 1'b1; e_num = 4'h0; e_wdata = 16'h0;
    chk("rst_late_ack_bus", 32'(bus_data_o), 32'h00);
    chk("rst_late_ack_dtack", 32'(bus_dtack_o), 32'(xv::DTACK_NAK));
    // Shadow byte was cleared by reset
    w0 = n_wr;
    do_write(4'h1, 1'b1, 8'h99, 0);
    idle(1, 0);
    chk("rst_msb_cleared", 32'(last_wdata), 32'h0099);
    chk("rst_wr_count", 32'(n_wr - w0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
